// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared reset PC, sequencer state and next-PC source encodings
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } seq_state_t;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD_PC,
    SEL_BR,
    SEL_J,
    SEL_JR
  } pc_sel_t;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational branch and jump target arithmetic
module pc_target_calc (
  input  logic [31:0] i_pc_plus4_ex,
  input  logic [15:0] i_imm16,
  input  logic [31:0] i_pc_plus4_id,
  input  logic [25:0] i_jump_index,
  output logic [31:0] o_br_target,
  output logic [31:0] o_j_target
);

  logic [31:0] w_br_offset;

  assign w_br_offset = {{14{i_imm16[15]}}, i_imm16, 2'b00};
  assign o_br_target = i_pc_plus4_ex + w_br_offset;
  assign o_j_target  = {i_pc_plus4_id[31:28], i_jump_index, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and next-PC arbiter for the 5-stage pipeline
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             ImemReady,
  input  logic             BranchEX,
  input  logic             BranchTaken,
  input  logic [15:0]      Imm16EX,
  input  logic [31:0]      PCPlus4EX,
  input  logic             JumpID,
  input  logic             JrID,
  input  logic [25:0]      JumpIndexID,
  input  logic [31:0]      PCPlus4ID,
  input  logic [31:0]      JrTargetID,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             FlushIF,
  output logic             FlushID,
  output logic             Redirect,
  output logic [CNT_W-1:0] RedirectCount
);

  seq_state_t       r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_pending;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_target;
  logic        w_br_taken;
  pc_sel_t     w_sel;

  pc_target_calc u_target_calc (
    .i_pc_plus4_ex (PCPlus4EX),
    .i_imm16       (Imm16EX),
    .i_pc_plus4_id (PCPlus4ID),
    .i_jump_index  (JumpIndexID),
    .o_br_target   (w_br_target),
    .o_j_target    (w_j_target)
  );

  assign w_br_taken = BranchEX & BranchTaken;

  // The older instruction in EX outranks the stall; ID-stage jumps do not.
  always_comb begin
    w_sel    = SEL_HOLD_PC;
    w_target = r_pending;
    FlushIF  = 1'b0;
    FlushID  = 1'b0;
    Redirect = 1'b0;
    if (!Reset) begin
      if (r_state == ST_RUN) begin
        if (w_br_taken) begin
          w_sel    = SEL_BR;
          w_target = w_br_target;
          FlushIF  = 1'b1;
          FlushID  = 1'b1;
          Redirect = 1'b1;
        end else if (JrID && !Stall) begin
          w_sel    = SEL_JR;
          w_target = JrTargetID;
          FlushIF  = 1'b1;
          Redirect = 1'b1;
        end else if (JumpID && !Stall) begin
          w_sel    = SEL_J;
          w_target = w_j_target;
          FlushIF  = 1'b1;
          Redirect = 1'b1;
        end else if (!Stall && ImemReady) begin
          w_sel = SEL_SEQ;
        end
      end else begin
        FlushIF = 1'b1;
        if (w_br_taken) begin
          w_sel    = SEL_BR;
          w_target = w_br_target;
          FlushID  = 1'b1;
          Redirect = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_pending <= 32'h0000_0000;
      r_cnt     <= '0;
    end else begin
      if (Redirect && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
      case (r_state)
        ST_RUN: begin
          if (Redirect) begin
            if (ImemReady) begin
              r_pc <= w_target;
            end else begin
              r_pending <= w_target;
              r_state   <= ST_HOLD;
            end
          end else if (w_sel == SEL_SEQ) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        ST_HOLD: begin
          if (ImemReady) begin
            r_pc    <= w_target;
            r_state <= ST_RUN;
          end else begin
            r_pending <= w_target;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign PC            = r_pc;
  assign PCPlus4       = r_pc + 32'd4;
  assign RedirectCount = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

  localparam int          CNT_W   = 16;
  localparam int unsigned CNT_MAX = 65535;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;

  logic             Clk = 1'b0;
  logic             Reset, Stall, ImemReady, BranchEX, BranchTaken, JumpID, JrID;
  logic [15:0]      Imm16EX;
  logic [31:0]      PCPlus4EX, PCPlus4ID, JrTargetID;
  logic [25:0]      JumpIndexID;
  logic [31:0]      PC, PCPlus4;
  logic             FlushIF, FlushID, Redirect;
  logic [CNT_W-1:0] RedirectCount;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .ImemReady(ImemReady),
    .BranchEX(BranchEX), .BranchTaken(BranchTaken), .Imm16EX(Imm16EX),
    .PCPlus4EX(PCPlus4EX), .JumpID(JumpID), .JrID(JrID),
    .JumpIndexID(JumpIndexID), .PCPlus4ID(PCPlus4ID), .JrTargetID(JrTargetID),
    .PC(PC), .PCPlus4(PCPlus4), .FlushIF(FlushIF), .FlushID(FlushID),
    .Redirect(Redirect), .RedirectCount(RedirectCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic        fi;
    logic        fd;
    logic        rd;
    int unsigned cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Model state: where fetch is, whether a redirect is parked, and how many redirects so far.
  logic [31:0] m_pc   = RST_PC;
  logic [31:0] m_pend = 32'h0;
  bit          m_hold = 1'b0;
  int unsigned m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit stall, input bit rdy,
                      input bit bex, input bit btk, input logic [15:0] imm,
                      input logic [31:0] p4ex, input bit jmp, input bit jr,
                      input logic [25:0] idx, input logic [31:0] p4id,
                      input logic [31:0] jrt);
    exp_t        e;
    logic [31:0] brt, jt, tgt;
    bit          br;
    @(posedge Clk);
    #1;
    Reset = rst; Stall = stall; ImemReady = rdy; BranchEX = bex; BranchTaken = btk;
    Imm16EX = imm; PCPlus4EX = p4ex; JumpID = jmp; JrID = jr;
    JumpIndexID = idx; PCPlus4ID = p4id; JrTargetID = jrt;

    br  = bex && btk;
    brt = p4ex + 32'($signed(imm)) * 32'd4;
    jt  = {p4id[31:28], idx, 2'b00};
    tgt = 32'h0;
    e.pc = m_pc; e.cnt = m_cnt; e.fi = 1'b0; e.fd = 1'b0; e.rd = 1'b0;
    if (!rst) begin
      if (m_hold) begin
        e.fi = 1'b1;
        if (br) begin e.rd = 1'b1; e.fd = 1'b1; tgt = brt; end
      end else if (br) begin
        e.rd = 1'b1; e.fi = 1'b1; e.fd = 1'b1; tgt = brt;
      end else if (!stall && jr) begin
        e.rd = 1'b1; e.fi = 1'b1; tgt = jrt;
      end else if (!stall && jmp) begin
        e.rd = 1'b1; e.fi = 1'b1; tgt = jt;
      end
    end
    q.push_back(e);

    if (rst) begin
      m_pc = RST_PC; m_pend = 32'h0; m_hold = 1'b0; m_cnt = 0;
    end else begin
      if (e.rd && m_cnt < CNT_MAX) m_cnt++;
      if (m_hold) begin
        if (br) m_pend = brt;
        if (rdy) begin m_pc = m_pend; m_hold = 1'b0; end
      end else if (e.rd) begin
        if (rdy) m_pc = tgt;
        else begin m_pend = tgt; m_hold = 1'b1; end
      end else if (!stall && rdy) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, rdy, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
  endtask

  // Outputs are presented every cycle, so the monitor consumes one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PC", PC, e.pc);
        chk("PCPlus4", PCPlus4, e.pc + 32'd4);
        chk("FlushIF", {31'h0, FlushIF}, {31'h0, e.fi});
        chk("FlushID", {31'h0, FlushID}, {31'h0, e.fd});
        chk("Redirect", {31'h0, Redirect}, {31'h0, e.rd});
        chk("RedirectCount", {16'h0, RedirectCount}, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Stall = 1'b0; ImemReady = 1'b1; BranchEX = 1'b0; BranchTaken = 1'b0;
    Imm16EX = 16'h0; PCPlus4EX = 32'h0; JumpID = 1'b0; JrID = 1'b0;
    JumpIndexID = 26'h0; PCPlus4ID = 32'h0; JrTargetID = 32'h0;
    @(posedge Clk);

    // Reset with a branch pending: flushes and redirect must stay low.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0010, 32'h200, 1'b1, 1'b0, 26'h1, 32'h0, 32'h0);
    repeat (5) idle(1'b1);

    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE, 32'h100, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
    repeat (2) idle(1'b1);

    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 26'h000_0040, 32'h4000_0010, 32'h0);
    idle(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 26'h000_0040, 32'h4000_0010, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 26'h0, 32'h0, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 26'h3, 32'h0, 32'h0000_0802);
    idle(1'b1);

    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0008, 32'h500, 1'b1, 1'b0, 26'h7, 32'h0, 32'h0);
    idle(1'b1);

    // Branch while memory is busy, a newer branch in HOLD, then release.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 32'h1000, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 26'h5, 32'h0, 32'hDEAD_BEEC);
    idle(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 32'h3000_0000, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
    idle(1'b1);
    idle(1'b1);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 32'h2000, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
    idle(1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
    repeat (3) idle(1'b1);

    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 32'hFFFF_FFFC, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
    repeat (2) idle(1'b1);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(3) == 0), ($urandom_range(3) != 0),
           ($urandom_range(3) == 0), ($urandom_range(1) == 1), 16'($urandom),
           $urandom, ($urandom_range(5) == 0), ($urandom_range(7) == 0),
           26'($urandom), $urandom, $urandom);
    end

    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
    for (int i = 0; i < 65540; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'($urandom), $urandom, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0);
    end
    repeat (3) idle(1'b1);

    @(posedge Clk);
    @(negedge Clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences next-PC selection for the 5-stage MIPS pipeline.
- Computes the branch target as PCPlus4EX + (sign-extended imm16 << 2) and the jump target as {PCPlus4ID[31:28], index26, 2'b00}.
- Arbitrates between competing redirects, stall and sequential fetch, and generates the IF/ID flushes.
- Holds a pending redirect while instruction memory is not ready.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating taken-redirect counter.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  hazard-unit stall; hold PC and do not flush.
- ImemReady  input  1  instruction memory accepts the fetch address this cycle.
- BranchEX  input  1  a conditional branch is in EX.
- BranchTaken  input  1  EX comparator result; qualified by BranchEX.
- Imm16EX  input  16  raw branch offset from the EX instruction.
- PCPlus4EX  input  32  PC+4 of the EX instruction.
- JumpID  input  1  j/jal decoded in ID.
- JrID  input  1  jr decoded in ID.
- JumpIndexID  input  26  instr[25:0] of the ID instruction.
- PCPlus4ID  input  32  PC+4 of the ID instruction.
- JrTargetID  input  32  forwarded rs value for jr.
- PC  output  32  current fetch address.
- PCPlus4  output  32  PC + 4, combinational from PC.
- FlushIF  output  1  squash the instruction being fetched this cycle.
- FlushID  output  1  squash the instruction in ID this cycle.
- Redirect  output  1  a non-sequential PC is being taken this cycle.
- RedirectCount  output  CNT_W  number of redirects taken since reset, saturating.

Behaviour:
- Reset (synchronous):
  - PC=RESET_PC, state=RUN, RedirectCount=0, pending target=0.
  - Combinational outputs FlushIF, FlushID and Redirect are 0 while Reset is high.
- Target arithmetic, modulo 2^32:
  - BrTarget = PCPlus4EX + ({{14{Imm16EX[15]}}, Imm16EX, 2'b00}).
  - JTarget = {PCPlus4ID[31:28], JumpIndexID, 2'b00}.
  - jr target = JrTargetID, used unaltered with no alignment fix.
- Request priority, evaluated each cycle in RUN (highest first):
  - 1. Taken branch (BranchEX & BranchTaken): target=BrTarget; FlushIF=1, FlushID=1. Applies even when Stall=1, because the older instruction wins over the stall.
  - 2. JrID: target=JrTargetID; FlushIF=1, FlushID=0. Ignored if Stall=1, since the rs forward may be invalid.
  - 3. JumpID: target=JTarget; FlushIF=1, FlushID=0. Ignored if Stall=1.
  - 4. Stall: PC holds, no flush.
  - 5. Otherwise PC <= PC+4, but only when ImemReady=1; else PC holds.
  - JrID and JumpID both high is illegal; jr wins.
- Redirect=1 in any cycle where case 1, 2 or 3 is accepted. RedirectCount increments on each Redirect and saturates at all-ones.
- FSM, two states:
  - RUN: a redirect with ImemReady=1 loads PC <= target and stays in RUN. A redirect with ImemReady=0 latches the target into the pending register and goes to HOLD; PC is unchanged.
  - HOLD: Stall, JumpID and JrID are ignored and FlushIF=1 every cycle. When ImemReady=1: PC <= pending, go to RUN.
  - HOLD with a new taken branch: the new BrTarget overwrites pending and Redirect pulses again; the state stays HOLD until ImemReady.
- Latency:
  - Redirect accepted in cycle N gives PC=target visible in cycle N+1.
  - A taken branch costs 2 bubbles; jump/jr costs 1.
- Reset asserted mid-HOLD discards the pending target, and PC=RESET_PC on the next edge.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, no flag.

Decomposition:
- Shared package mips_pkg:
  - RESET_PC default.
  - State encodings RUN=1'b0, HOLD=1'b1.
  - Next-PC source select encoding: SEQ, HOLD_PC, BR, J, JR.
- One sub-module pc_target_calc:
  - Purely combinational BrTarget/JTarget computation: sign-extend, <<2, add, concatenate.
  - Reusable by the branch-prediction work that follows.

Test Plan:
- Reset then 4 cycles, ImemReady=1, no requests -> PC sequence 0,4,8,C,10; RedirectCount=0.
- PCPlus4EX=32'h100, Imm16EX=16'hFFFE, BranchEX=BranchTaken=1 -> next PC=32'hF8; FlushIF=FlushID=1 for one cycle; RedirectCount=1.
- JumpID=1, PCPlus4ID=32'h4000_0010, JumpIndexID=26'h000_0040 -> PC=32'h4000_0100, FlushIF=1, FlushID=0. Repeat with Stall=1 -> PC holds, no flush.
- Taken branch with Stall=1 and JumpID=1 simultaneously -> branch target taken, jump ignored, both flushes asserted.
- Branch taken with ImemReady=0 for 3 cycles -> PC holds, FSM in HOLD, FlushIF=1 each cycle; on ImemReady=1, PC=BrTarget next cycle.
- Reset asserted during HOLD -> PC=RESET_PC next cycle, state RUN, pending target discarded. Counter preset near saturation (0xFFFF) plus one more redirect -> stays 0xFFFF.
